// File: rtl/systolic_readback_if.sv
// Row stream leaving the systolic result readback: payload plus valid/ready handshake.
interface systolic_readback_if #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 16
);
  logic                             out_valid;
  logic                             out_ready;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_data;
  logic [5:0]                       out_index;
  logic                             out_last;

  modport master (output out_valid, out_data, out_index, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_index, out_last, output out_ready);
endinterface

// File: rtl/systolic_readback.sv
// Reads NUM_ROWS rows from the result SRAM after tpu_done and streams them through a 2-entry skid FIFO.
// Optional macro READBACK_RELU_EN clamps negative elements to zero at FIFO capture.
module systolic_readback #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_ROWS   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             tpu_done,
  output logic                             sram_read_enable,
  output logic [5:0]                       sram_raddr,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] sram_rdata,
  output logic                             busy,
  output logic                             rb_done,
  systolic_readback_if.master              out_if
);
  localparam int         ROW_W     = ARRAY_SIZE * DATA_WIDTH;
  localparam logic [5:0] LAST_ADDR = 6'(NUM_ROWS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [5:0]       raddr_q, raddr_d;
  logic             inflight_q, inflight_d;
  logic [5:0]       inflight_addr_q, inflight_addr_d;
  logic             rb_done_q, rb_done_d;
  logic [ROW_W-1:0] mem_data_q [2];
  logic [ROW_W-1:0] mem_data_d [2];
  logic [5:0]       mem_index_q [2];
  logic [5:0]       mem_index_d [2];
  logic             mem_last_q [2];
  logic             mem_last_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  logic             head_valid;
  logic             head_last;
  logic             pop;
  logic             issue;
  logic [1:0]       outstanding;
  logic [ROW_W-1:0] capture_data;

  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_elem
`ifdef READBACK_RELU_EN
    assign capture_data[gi*DATA_WIDTH +: DATA_WIDTH] =
        sram_rdata[gi*DATA_WIDTH + DATA_WIDTH - 1] ? '0 : sram_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
`else
    assign capture_data[gi*DATA_WIDTH +: DATA_WIDTH] = sram_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
`endif
  end

  assign head_valid  = (count_q != 2'd0);
  assign head_last   = mem_last_q[rd_ptr_q];
  assign pop         = head_valid && out_if.out_ready;
  // Rows already committed (buffered or arriving next cycle) must never exceed the FIFO depth.
  assign outstanding = count_q + {1'b0, inflight_q};
  assign issue       = (state_q == READ) &&
                       ((outstanding < 2'd2) || ((outstanding == 2'd2) && pop));

  always_comb begin
    state_d         = state_q;
    raddr_d         = raddr_q;
    inflight_d      = issue;
    inflight_addr_d = issue ? raddr_q : inflight_addr_q;
    rb_done_d       = 1'b0;
    mem_data_d      = mem_data_q;
    mem_index_d     = mem_index_q;
    mem_last_d      = mem_last_q;
    wr_ptr_d        = wr_ptr_q ^ inflight_q;
    rd_ptr_d        = rd_ptr_q ^ pop;
    count_d         = count_q + {1'b0, inflight_q} - {1'b0, pop};

    if (inflight_q) begin
      mem_data_d[wr_ptr_q]  = capture_data;
      mem_index_d[wr_ptr_q] = inflight_addr_q;
      mem_last_d[wr_ptr_q]  = (inflight_addr_q == LAST_ADDR);
    end

    case (state_q)
      IDLE: begin
        raddr_d = '0;
        if (tpu_done) state_d = READ;
      end
      READ: begin
        if (issue) begin
          raddr_d = raddr_q + 6'd1;
          if (raddr_q == LAST_ADDR) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_d   = IDLE;
          raddr_d   = '0;
          rb_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      raddr_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      rb_done_q       <= 1'b0;
      mem_data_q      <= '{default: '0};
      mem_index_q     <= '{default: '0};
      mem_last_q      <= '{default: 1'b0};
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      raddr_q         <= raddr_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      rb_done_q       <= rb_done_d;
      mem_data_q      <= mem_data_d;
      mem_index_q     <= mem_index_d;
      mem_last_q      <= mem_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  assign sram_read_enable = issue;
  assign sram_raddr       = raddr_q;
  assign busy             = (state_q != IDLE);
  assign rb_done          = rb_done_q;
  assign out_if.out_valid = head_valid;
  assign out_if.out_data  = mem_data_q[rd_ptr_q];
  assign out_if.out_index = mem_index_q[rd_ptr_q];
  assign out_if.out_last  = head_last;
endmodule
